alu_arbiter: RTL and testbench

Shares the single 7-bit ALU datapath between two independent requesters using round-robin arbitration with valid/ready handshakes. Operands and opcode are registered on grant, and the ALU is evaluated from those registers. The result is registered and returned on the granted requester's response channel, where it is held under backpressure. The block sits between the two client blocks and the combinational ALU, which it instantiates.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_arbiter_alu.sv | 34 +++
 rtl/alu_arbiter.sv | 156 +++++++++++++++
 tb/tb_alu_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared opcodes, datapath width and arbiter state encoding.
// Rev     : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_W = 7;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_ROL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
`default_nettype none
// ============================================================================
// Module  : alu_arbiter_alu
// Brief   : Combinational W-bit ALU (ADD, SUB, NAND, rotate-left).
// Rev     : 1.0  initial release
// ============================================================================
module alu_arbiter_alu
    import alu_pkg::*;
#(
    parameter int W = ALU_W
)(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    output logic [W-1:0] r
);

    int               w_sh;
    logic [2*W-1:0]   w_rot;

    always_comb begin
        // Rotate amount is B[2:0] modulo the width, so 7 on a 7-bit ALU is a no-op.
        w_sh  = int'(b[2:0]) % W;
        w_rot = {a, a} << w_sh;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_NAND: r = ~(a & b);
            default: r = w_rot[2*W-1 -: W];
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : alu_arbiter
// Brief   : Round-robin sharing of one ALU between two valid/ready clients.
//           Define ALU_ARB_STATS_EN to add saturating per-requester grant counters.
// Rev     : 1.0  initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W = ALU_W
`ifdef ALU_ARB_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [W-1:0]     req_a0,
    input  logic [W-1:0]     req_a1,
    input  logic [W-1:0]     req_b0,
    input  logic [W-1:0]     req_b1,
    input  logic [1:0]       req_op0,
    input  logic [1:0]       req_op1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [W-1:0]     rsp_data,
`ifdef ALU_ARB_STATS_EN
    input  logic             stats_clr,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1,
`endif
    output logic             busy
);

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_ptr;
    logic         r_gnt;
    logic         w_gnt;
    logic         w_any;
    logic         w_accept;
    logic         w_done;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [1:0]   r_op;
    logic [W-1:0] r_rsp_data;
    logic [W-1:0] w_alu_r;

    // Pointer only breaks ties; a lone requester is always granted.
    always_comb begin
        w_any = |req_valid;
        w_gnt = (&req_valid) ? r_ptr : req_valid[1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 2'b00;
        rsp_valid   = 2'b00;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    req_ready[w_gnt] = 1'b1;
                    w_accept         = 1'b1;
                    w_state_nxt      = EXEC;
                end
            end
            EXEC: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                rsp_valid[r_gnt] = 1'b1;
                if (rsp_ready[r_gnt]) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr      <= 1'b0;
            r_gnt      <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= OP_ADD;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_gnt <= w_gnt;
                r_a   <= w_gnt ? req_a1  : req_a0;
                r_b   <= w_gnt ? req_b1  : req_b0;
                r_op  <= w_gnt ? req_op1 : req_op0;
            end
            if (r_state == EXEC) begin
                r_rsp_data <= w_alu_r;
            end
            if (w_done) begin
                r_ptr <= ~r_gnt;
            end
        end
    end

    alu_arbiter_alu #(
        .W  (W)
    ) u_alu (
        .a  (r_a),
        .b  (r_b),
        .op (r_op),
        .r  (w_alu_r)
    );

    assign rsp_data = r_rsp_data;
    assign busy     = (r_state != IDLE);

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    // Clear wins over increment; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n || stats_clr) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_accept && !w_gnt && !(&r_cnt0)) begin
                r_cnt0 <= r_cnt0 + CNT_W'(1);
            end
            if (w_accept && w_gnt && !(&r_cnt1)) begin
                r_cnt1 <= r_cnt1 + CNT_W'(1);
            end
        end
    end

    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_arbiter
// Brief   : Scoreboard bench for alu_arbiter with a transaction-level model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int W = 7;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic [1:0]   req_valid = 2'b00;
    logic [1:0]   req_ready;
    logic [W-1:0] req_a0    = '0;
    logic [W-1:0] req_a1    = '0;
    logic [W-1:0] req_b0    = '0;
    logic [W-1:0] req_b1    = '0;
    logic [1:0]   req_op0   = 2'b00;
    logic [1:0]   req_op1   = 2'b00;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready = 2'b00;
    logic [W-1:0] rsp_data;
    logic         busy;
`ifdef ALU_ARB_STATS_EN
    logic         stats_clr = 1'b0;
    logic [15:0]  grant_cnt0;
    logic [15:0]  grant_cnt1;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        int           id;
        logic [W-1:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] rr_val  = 2'b00;
    bit         rr_rand = 1'b0;
    int         m_ptr   = 0;
    int         m_cnt[2] = '{0, 0};

    alu_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a0     (req_a0),
        .req_a1     (req_a1),
        .req_b0     (req_b0),
        .req_b1     (req_b1),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
`ifdef ALU_ARB_STATS_EN
        .stats_clr  (stats_clr),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        rsp_ready = rr_rand ? 2'($urandom) : rr_val;
    end

    function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] op);
        int           ai;
        int           bi;
        int           n;
        logic [W-1:0] r;
        ai = int'(a);
        bi = int'(b);
        case (op)
            2'd0:    r = W'((ai + bi) % (1 << W));
            2'd1:    r = W'((ai - bi + (1 << W)) % (1 << W));
            2'd2:    r = ~(a & b);
            default: begin
                r = a;
                n = (bi % 8) % W;
                repeat (n) r = {r[W-2:0], r[W-1]};
            end
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every response handshake.
    bit           p_wait = 1'b0;
    logic [W-1:0] p_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_wait = 1'b0;
        end else if (rsp_valid != 2'b00) begin
            int   g;
            exp_t e;
            g = rsp_valid[1] ? 1 : 0;
            check("rsp_onehot", 32'($countones(rsp_valid)), 32'd1);
            check("rdy_in_resp", 32'(req_ready), 32'd0);
            if (p_wait) check("rsp_hold", 32'(rsp_data), 32'(p_data));
            if (rsp_ready[g]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got requester %0d data %0h, none expected", g, rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id", 32'(g), 32'(e.id));
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                end
                p_wait = 1'b0;
            end else begin
                p_wait = 1'b1;
                p_data = rsp_data;
            end
        end else if (p_wait) begin
            checks++;
            errors++;
            $display("FAIL rsp_dropped: got rsp_valid 0 required held response");
            p_wait = 1'b0;
        end
    end

    task automatic reset_dut();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        m_ptr    = 0;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        exp_q.delete();
    endtask

    // Presents requests together; each drops after acceptance. Model decides service order.
    task automatic run_round(input logic [1:0] mask,
                             input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [1:0] op0,
                             input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [1:0] op1);
        int         first;
        int         second;
        int         budget;
        logic [1:0] acc;
        exp_t       e;
        first  = (mask == 2'b11) ? m_ptr : (mask[1] ? 1 : 0);
        e.id   = first;
        e.data = (first == 1) ? ref_alu(a1, b1, op1) : ref_alu(a0, b0, op0);
        exp_q.push_back(e);
        m_cnt[first]++;
        if (mask == 2'b11) begin
            second = 1 - first;
            e.id   = second;
            e.data = (second == 1) ? ref_alu(a1, b1, op1) : ref_alu(a0, b0, op0);
            exp_q.push_back(e);
            m_cnt[second]++;
            m_ptr = 1 - second;
        end else begin
            m_ptr = 1 - first;
        end
        req_a0 = a0; req_b0 = b0; req_op0 = op0;
        req_a1 = a1; req_b1 = b1; req_op1 = op1;
        req_valid = mask;
        budget = 0;
        while ((req_valid != 2'b00 || busy || exp_q.size() != 0) && budget < 200) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk); #1;
            req_valid = req_valid & ~acc;
            budget++;
        end
        if (budget >= 200) begin
            checks++;
            errors++;
            $display("FAIL round_timeout: got %0d pending responses required 0", exp_q.size());
            exp_q.delete();
            req_valid = 2'b00;
        end
    endtask

    task automatic rand_round(input logic [1:0] mask);
        run_round(mask, W'($urandom), W'($urandom), 2'($urandom),
                        W'($urandom), W'($urandom), 2'($urandom));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_t e;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single ADD on requester 0 with fixed timing checks.
        rr_val = 2'b01;
        req_a0 = 7'b0010100; req_b0 = 7'b0001111; req_op0 = 2'b00;
        e.id = 0; e.data = 7'b0100011;
        exp_q.push_back(e);
        req_valid = 2'b01;
        @(negedge clk);
        check("t1_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        check("t1_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t1_exec_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_resp_rsp_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk); #1;
        check("t1_done_busy", 32'(busy), 32'd0);

        // Simultaneous requests straight after reset: requester 0 first.
        reset_dut();
        rr_val = 2'b11;
        run_round(2'b11, 7'b1010101, 7'b0101010, 2'b10, 7'b1110000, 7'b0000011, 2'b01);

        // Backpressure on requester 1; ready on the other channel must be ignored.
        rr_val = 2'b01;
        req_a1 = 7'b0001111; req_b1 = 7'b0000100; req_op1 = 2'b11;
        e.id = 1; e.data = 7'b1110001;
        exp_q.push_back(e);
        m_cnt[1]++;
        m_ptr = 0;
        req_valid = 2'b10;
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_rsp_valid", 32'(rsp_valid), 32'd2);
            check("t3_rsp_data", 32'(rsp_data), 32'(7'b1110001));
            check("t3_req_ready", 32'(req_ready), 32'd0);
            check("t3_busy", 32'(busy), 32'd1);
        end
        @(posedge clk); #1;
        rr_val = 2'b10;
        @(posedge clk); #1;
        check("t3_done_busy", 32'(busy), 32'd0);

        // Continuous dual requests, then random traffic with random backpressure.
        rr_rand = 1'b1;
        repeat (3) rand_round(2'b11);
        repeat (20) begin
            rand_round(2'($urandom_range(1, 3)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        // Reset during EXEC drops the operation silently.
        rr_rand = 1'b0;
        rr_val  = 2'b11;
        req_a0 = W'($urandom); req_b0 = W'($urandom); req_op0 = 2'($urandom);
        req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b00;
        rst_n     = 1'b0;
        @(negedge clk);
        check("t5_exec_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst_n    = 1'b1;
        m_ptr    = 0;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        @(negedge clk);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t5_rsp_data", 32'(rsp_data), 32'd0);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        rand_round(2'b11);

`ifdef ALU_ARB_STATS_EN
        reset_dut();
        rr_rand = 1'b1;
        rand_round(2'b11);
        rand_round(2'b11);
        rand_round(2'b01);
        @(negedge clk);
        check("t6_cnt0", 32'(grant_cnt0), 32'd3);
        check("t6_cnt1", 32'(grant_cnt1), 32'd2);
        check("t6_cnt0_model", 32'(grant_cnt0), 32'(m_cnt[0]));
        @(posedge clk); #1;
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        @(negedge clk);
        check("t6_clr_cnt0", 32'(grant_cnt0), 32'd0);
        check("t6_clr_cnt1", 32'(grant_cnt1), 32'd0);
`endif

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover: got %0d pending responses required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
